serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 106 ++++++++++
 tb/tb_serial_adder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder stage per cycle.
// Operands shift out LSB-first; the result is registered on completion.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state, state_n;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] ps;
   logic             c;
   logic [CW-1:0]    cnt;

   logic s;
   logic c_n;
   logic last;

   assign s    = a_sr[0] ^ b_sr[0] ^ c;
   assign c_n  = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
   assign last = (cnt == CW'(WIDTH - 1));

   // busy decodes the state register only, so it stays registered
   assign busy = (state != IDLE);

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // next-state logic; DONE always falls back to IDLE
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (start) state_n = RUN;
         RUN:     if (last)  state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // datapath: capture, serial add, final result load
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr <= '0;
         b_sr <= '0;
         ps   <= '0;
         c    <= 1'b0;
         cnt  <= '0;
         sum  <= '0;
         cout <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_sr <= a;
                  b_sr <= b;
                  ps   <= '0;
                  c    <= cin;
                  cnt  <= '0;
               end
            end
            RUN: begin
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               ps   <= {s, ps[WIDTH-1:1]};
               c    <= c_n;
               cnt  <= cnt + CW'(1);
               if (last) begin
                  sum  <= {s, ps[WIDTH-1:1]};
                  cout <= c_n;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // done pulses for the single cycle following DONE
   always_ff @(posedge clk) begin
      if (rst) done <= 1'b0;
      else     done <= (state == DONE);
   end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors for WIDTH=8 plus
// an exhaustive WIDTH=4 sweep against a behavioural sum.
module tb_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;

   logic       start4;
   logic [3:0] a4;
   logic [3:0] b4;
   logic       cin4;
   logic       busy4;
   logic       done4;
   logic [3:0] sum4;
   logic       cout4;

   serial_adder #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   serial_adder #(.WIDTH(4)) dut4 (
      .clk   (clk),
      .rst   (rst),
      .start (start4),
      .a     (a4),
      .b     (b4),
      .cin   (cin4),
      .busy  (busy4),
      .done  (done4),
      .sum   (sum4),
      .cout  (cout4)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      logic [7:0] s;
      logic       co;
      int         pulse_at;
   } vec_t;

   vec_t       tbl[7];
   vec_t       held[4];
   int         ncmp = 0;
   int         nerr = 0;
   logic [7:0] prev_sum;
   logic       prev_cout;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic op8(input vec_t v, input string nm);
      int nb;
      int nd;
      int dk;
      @(posedge clk); #1;
      start = 1'b1; a = v.a; b = v.b; cin = v.c;
      @(posedge clk); #1;
      start = 1'b0; a = ~v.a; b = ~v.b; cin = ~v.c;
      nb = 0; nd = 0; dk = -1;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (busy) nb++;
         if (done) begin
            nd++;
            if (dk < 0) dk = k;
         end
         if (k == 7) begin
            chk({nm, " hold sum"}, 32'(sum), 32'(prev_sum));
            chk({nm, " hold cout"}, 32'(cout), 32'(prev_cout));
         end
         if (k == v.pulse_at) begin
            start = 1'b1; a = 8'hAA; b = 8'h55;
         end else begin
            start = 1'b0;
         end
      end
      chk({nm, " latency"}, 32'(dk), 32'd9);
      chk({nm, " busy cycles"}, 32'(nb), 32'd9);
      chk({nm, " done pulses"}, 32'(nd), 32'd1);
      chk({nm, " sum"}, 32'(sum), 32'(v.s));
      chk({nm, " cout"}, 32'(cout), 32'(v.co));
      prev_sum  = v.s;
      prev_cout = v.co;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t       v;
      int         nd;
      int         i;
      int         lastk;
      logic       got;
      logic [4:0] m;
      logic [8:0] x9;

      tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, -1};
      tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, -1};
      tbl[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 3};
      tbl[3] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, -1};
      tbl[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, -1};
      tbl[5] = '{8'hC3, 8'h3C, 1'b0, 8'hFF, 1'b0, -1};
      tbl[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, -1};

      held[0] = '{8'h11, 8'h22, 1'b0, 8'h33, 1'b0, -1};
      held[1] = '{8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, -1};
      held[2] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, -1};
      held[3] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, -1};

      rst = 1'b1; start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
      start4 = 1'b1; a4 = 4'h3; b4 = 4'h4; cin4 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0; start = 1'b0; start4 = 1'b0;
      @(negedge clk);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset sum", 32'(sum), 32'd0);
      chk("reset cout", 32'(cout), 32'd0);
      chk("reset busy4", 32'(busy4), 32'd0);
      chk("reset sum4", 32'({cout4, sum4}), 32'd0);
      prev_sum = 8'h00; prev_cout = 1'b0;

      for (int n = 0; n < 7; n++) begin
         op8(tbl[n], $sformatf("vec%0d", n));
      end

      @(posedge clk); #1;
      start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort sum", 32'(sum), 32'd0);
      chk("abort cout", 32'(cout), 32'd0);
      nd = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("abort done pulses", 32'(nd), 32'd0);
      prev_sum = 8'h00; prev_cout = 1'b0;

      v = '{8'h03, 8'h04, 1'b1, 8'h08, 1'b0, -1};
      op8(v, "after abort");

      @(posedge clk); #1;
      start = 1'b1;
      a = held[0].a; b = held[0].b; cin = held[0].c;
      i = 0; lastk = -1;
      for (int k = 0; k < 80 && i < 4; k++) begin
         @(negedge clk);
         if (done) begin
            chk($sformatf("held%0d sum", i), 32'(sum), 32'(held[i].s));
            chk($sformatf("held%0d cout", i), 32'(cout),
                32'(held[i].co));
            if (i == 0)
               chk("held first latency", 32'(k), 32'd10);
            else
               chk($sformatf("held%0d period", i), 32'(k - lastk),
                   32'd10);
            lastk = k;
            i++;
            if (i < 4) begin
               a = held[i].a; b = held[i].b; cin = held[i].c;
            end else begin
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      chk("held results", 32'(i), 32'd4);
      repeat (15) @(posedge clk);

      for (int n = 0; n < 512; n++) begin
         x9 = n[8:0];
         @(posedge clk); #1;
         start4 = 1'b1;
         cin4 = x9[8]; a4 = x9[7:4]; b4 = x9[3:0];
         m = 5'(x9[7:4]) + 5'(x9[3:0]) + 5'(x9[8]);
         @(posedge clk); #1;
         start4 = 1'b0;
         a4 = ~a4; b4 = ~b4; cin4 = ~cin4;
         got = 1'b0;
         for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (done4) got = 1'b1;
         end
         chk($sformatf("w4 a=%0h b=%0h c=%0d", x9[7:4], x9[3:0], x9[8]),
             32'({got, cout4, sum4}), 32'({1'b1, m}));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nerr);
      $finish;
   end

endmodule
